ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Parametrised control-path sequencer for the CISC CPU family. It consumes decoded micro-op control words and sequences multi-cycle operations:
- multi-byte immediate fetch from the instruction byte stream;
- RAM write with handshake;
- RAM read with handshake.

It sits between the micro-op decoder and the datapath (register stack, IP register, ALU) and drives the memory interface. It generalises the previous 8-bit-only, single-byte control unit to DATA_W/ADDR_W-wide operands and adds ready/valid handshakes, a memory timeout and an error report.

Parameters:
DATA_W, 8, datapath width in bits; multiple of 8, range 8..32
ADDR_W, 8, memory address width in bits; range 8..16
TIMEOUT, 15, maximum cycles to wait for mem_ready before aborting; range 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ctrl_valid  in  1  control word present
ctrl_ready  out  1  sequencer can accept a control word (high only in IDLE)
ctrl_mode  in  2  0=EXEC, 1=IMM, 2=MWR, 3=MRD
ctrl_nbytes  in  3  immediate byte count for IMM
ibuf  in  8  instruction byte stream
ibuf_valid  in  1  ibuf byte valid this cycle
ibuf_take  out  1  byte consumed this cycle
wr_data  in  DATA_W  store data from register stack
exec_pulse  out  1  one-cycle strobe: datapath executes the EXEC word
imm_data  out  DATA_W  assembled immediate
imm_valid  out  1  one-cycle strobe: imm_data valid
mem_csel  out  1  memory chip select
mem_read_en  out  1  1=read, 0=write (meaningful only when mem_csel=1)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data
mem_ready  in  1  memory completes access this cycle
rd_data  out  DATA_W  captured read data
rd_valid  out  1  one-cycle strobe: rd_data valid
err  out  1  one-cycle strobe: memory timeout
status  out  2  registered current state code

Behaviour:
Clock and reset:
- Single clock clk; asynchronous active-low reset rst_n.
- On reset: state=IDLE, status=0, all strobes 0, mem_csel=0, mem_read_en=0, mem_addr=0, imm_data=0, rd_data=0, byte and timeout counters 0.
- Reset mid-operation abandons the operation with no strobe emitted.

State codes: IDLE=0, IMM=1, MWR=2, MRD=3. status equals the state register in every cycle.

IDLE:
- ctrl_ready=1.
- ctrl_valid with mode 0: exec_pulse=1 in the next cycle; state stays IDLE; back-to-back EXEC words are accepted every cycle.
- Mode 1: latch count n = max(1, min(ctrl_nbytes, DATA_W/8)), then enter IMM.
- Mode 2: latch wr_data, enter MWR.
- Mode 3: enter MRD.

Non-IDLE states:
- ctrl_ready=0; ctrl_valid is ignored, with no queuing.

Byte assembly (IMM, and address phase of MWR/MRD):
- ibuf_take = ibuf_valid while bytes remain.
- Byte k (0-based) is written to bits [8k+7:8k], little-endian.
- Unwritten upper bits are 0.
- Cycles with no valid byte stall indefinitely and do not count toward timeout.

IMM:
- After the n-th byte is taken, imm_valid=1 with the final imm_data in the next cycle; return to IDLE the same cycle.
- imm_data holds its value until the next IMM.

MWR/MRD address phase:
- Collect ceil(ADDR_W/8) bytes into mem_addr; bits above ADDR_W are discarded.

MWR/MRD access phase:
- Starts the cycle after the last address byte.
- mem_csel=1; mem_read_en=1 for MRD, 0 for MWR.
- mem_addr and mem_wdata are held stable.
- The timeout counter increments each cycle mem_ready=0.

Completion:
- mem_ready=1: deassert mem_csel next cycle and return to IDLE.
- MRD additionally captures rd_data <= mem_rdata and pulses rd_valid in that next cycle.
- If mem_ready and the counter reaching TIMEOUT coincide, the access completes with no err.
- Counter reaches TIMEOUT with mem_ready=0: err=1 for one cycle, mem_csel=0, return to IDLE, rd_data unchanged.

Decomposition:
- Shared package ctrl_pkg:
  - state encodings IDLE/IMM/MWR/MRD;
  - mode encodings EXEC/IMM/MWR/MRD;
  - helper constant function for byte counts (ceil(W/8)).
- One sub-module, byte_assembler (parameter W):
  - start/load-count, ibuf/ibuf_valid in;
  - take, done, value[W-1:0] out;
  - instantiated once for the immediate path and once for the address path.

Test Plan:
1. DATA_W=16: IMM with nbytes=2, ibuf 0x34 then 0x12 -> imm_data=0x1234, imm_valid for one cycle, status 1 then 0.
2. DATA_W=16: IMM with nbytes=0, ibuf 0xAB -> imm_data=0x00AB (count treated as 1).
3. DATA_W=16: IMM with nbytes=5 -> exactly 2 bytes taken (clamped).
4. MWR with ADDR_W=8, wr_data=0x5A, address byte 0x80, mem_ready after 3 cycles -> mem_csel high 4 cycles, mem_addr=0x80, mem_wdata=0x5A, mem_read_en=0, no err.
5. MRD with ADDR_W=16, address bytes 0x00, 0x01, then mem_rdata=0xC3 and mem_ready -> mem_addr=0x0100, rd_data=0xC3, rd_valid pulse.
6. MRD with mem_ready held 0 and TIMEOUT=4 -> err pulse after 4 wait cycles, mem_csel=0, return to IDLE.
7. Reset asserted mid-IMM after one byte -> all outputs 0 immediately; next IMM starts fresh at byte 0.
8. ctrl_valid held during MWR -> ignored, ctrl_ready=0.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_pkg: shared definitions for the control-path sequencer.
//   state_e     - sequencer state codes, also driven out on status
//   mode_e      - control word mode field encodings
//   byte_count  - number of whole bytes needed to cover a W-bit field
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_MWR  = 2'd2,
        ST_MRD  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_EXEC = 2'd0,
        MODE_IMM  = 2'd1,
        MODE_MWR  = 2'd2,
        MODE_MRD  = 2'd3
    } mode_e;

    function automatic int byte_count(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_byte_assembler.sv
// byte_assembler: collects a programmed number of bytes from the instruction
// byte stream into a little-endian word.
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - clear the word and load count (bytes to collect)
//   count             - number of bytes to collect, 1..byte_count(W)
//   ibuf, ibuf_valid  - instruction byte stream
//   take              - byte consumed this cycle
//   done              - the final byte is consumed this cycle
//   value             - assembled word; bits not yet written read as 0
module byte_assembler
    import ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   count,
    input  logic [7:0]   ibuf,
    input  logic         ibuf_valid,
    output logic         take,
    output logic         done,
    output logic [W-1:0] value
);

    localparam int NB = byte_count(W);
    localparam int VW = 8 * NB;

    logic [2:0]    rem_q;
    logic [1:0]    idx_q;
    logic [VW-1:0] val_q;

    // Idle whenever no bytes remain, so an unused assembler never takes.
    assign take  = ibuf_valid && (rem_q != 3'd0);
    assign done  = take && (rem_q == 3'd1);
    // Bits beyond W (only when W is not a byte multiple) are discarded.
    assign value = val_q[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= 3'd0;
            idx_q <= 2'd0;
            val_q <= '0;
        end else if (start) begin
            rem_q <= count;
            idx_q <= 2'd0;
            val_q <= '0;
        end else if (take) begin
            for (int k = 0; k < NB; k++) begin
                if (int'(idx_q) == k) begin
                    val_q[8*k +: 8] <= ibuf;
                end
            end
            idx_q <= idx_q + 2'd1;
            rem_q <= rem_q - 3'd1;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: sequences multi-cycle micro-ops (immediate fetch, RAM
// write, RAM read) between the micro-op decoder, the datapath and memory.
//   ctrl_*                - control word handshake and fields
//   ibuf*                 - instruction byte stream, consumed via ibuf_take
//   wr_data               - store data, latched when an MWR word is accepted
//   exec_pulse            - strobe: datapath executes an EXEC word
//   imm_data/imm_valid    - assembled immediate and its strobe
//   mem_*                 - memory interface (csel, read_en, addr, wdata,
//                           rdata, ready)
//   rd_data/rd_valid      - captured read data and its strobe
//   err                   - strobe: memory access timed out
//   status                - current state code
//
// Handshake: a control word transfers on a cycle where ctrl_valid and
// ctrl_ready are both high; ctrl_ready is high only in IDLE and words
// offered at other times are dropped, not queued. An ibuf byte transfers
// on a cycle where ibuf_valid and ibuf_take are both high. A memory access
// completes on the first cycle with mem_csel and mem_ready both high, or
// aborts after TIMEOUT cycles of mem_ready low.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic [1:0]        ctrl_mode,
    input  logic [2:0]        ctrl_nbytes,
    input  logic [7:0]        ibuf,
    input  logic              ibuf_valid,
    output logic              ibuf_take,
    input  logic [DATA_W-1:0] wr_data,
    output logic              exec_pulse,
    output logic [DATA_W-1:0] imm_data,
    output logic              imm_valid,
    output logic              mem_csel,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic [1:0]        status
);

    localparam logic [2:0] DB3     = 3'(byte_count(DATA_W));
    localparam logic [2:0] AB3     = 3'(byte_count(ADDR_W));
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic              exec_q, immv_q, rdv_q, err_q;
    logic              csel_q, rden_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [7:0]        to_cnt_q;

    logic       idle, accept;
    logic       imm_start, addr_start;
    logic       imm_take, imm_done, addr_take, addr_done;
    logic [2:0] imm_cnt_d;

    assign idle       = (state_q == ST_IDLE);
    assign accept     = ctrl_valid && idle;
    assign imm_start  = accept && (ctrl_mode == MODE_IMM);
    assign addr_start = accept && ((ctrl_mode == MODE_MWR) || (ctrl_mode == MODE_MRD));

    // Immediate byte count clamped to 1..bytes-per-word.
    always_comb begin
        imm_cnt_d = ctrl_nbytes;
        if (ctrl_nbytes == 3'd0) begin
            imm_cnt_d = 3'd1;
        end else if (ctrl_nbytes > DB3) begin
            imm_cnt_d = DB3;
        end
    end

    byte_assembler #(.W(DATA_W)) u_imm_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (imm_start),
        .count      (imm_cnt_d),
        .ibuf       (ibuf),
        .ibuf_valid (ibuf_valid),
        .take       (imm_take),
        .done       (imm_done),
        .value      (imm_data)
    );

    byte_assembler #(.W(ADDR_W)) u_addr_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (addr_start),
        .count      (AB3),
        .ibuf       (ibuf),
        .ibuf_valid (ibuf_valid),
        .take       (addr_take),
        .done       (addr_done),
        .value      (mem_addr)
    );

    // At most one assembler has bytes outstanding at any time.
    assign ibuf_take = imm_take | addr_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            exec_q   <= 1'b0;
            immv_q   <= 1'b0;
            rdv_q    <= 1'b0;
            err_q    <= 1'b0;
            csel_q   <= 1'b0;
            rden_q   <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            to_cnt_q <= 8'd0;
        end else begin
            exec_q <= 1'b0;
            immv_q <= 1'b0;
            rdv_q  <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_valid) begin
                        case (ctrl_mode)
                            MODE_EXEC: exec_q <= 1'b1;
                            MODE_IMM:  state_q <= ST_IMM;
                            MODE_MWR: begin
                                wdata_q <= wr_data;
                                state_q <= ST_MWR;
                            end
                            default:   state_q <= ST_MRD;
                        endcase
                    end
                end
                ST_IMM: begin
                    if (imm_done) begin
                        immv_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    // csel low: address phase; csel high: access phase.
                    if (!csel_q) begin
                        if (addr_done) begin
                            csel_q   <= 1'b1;
                            rden_q   <= (state_q == ST_MRD);
                            to_cnt_q <= 8'd0;
                        end
                    end else if (mem_ready) begin
                        // Completion wins over a simultaneous timeout.
                        csel_q   <= 1'b0;
                        rden_q   <= 1'b0;
                        to_cnt_q <= 8'd0;
                        state_q  <= ST_IDLE;
                        if (state_q == ST_MRD) begin
                            rdata_q <= mem_rdata;
                            rdv_q   <= 1'b1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q    <= 1'b1;
                        csel_q   <= 1'b0;
                        rden_q   <= 1'b0;
                        to_cnt_q <= 8'd0;
                        state_q  <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign ctrl_ready  = idle;
    assign exec_pulse  = exec_q;
    assign imm_valid   = immv_q;
    assign mem_csel    = csel_q;
    assign mem_read_en = rden_q;
    assign mem_wdata   = wdata_q;
    assign rd_data     = rdata_q;
    assign rd_valid    = rdv_q;
    assign err         = err_q;
    assign status      = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;
  localparam int DB      = DATA_W / 8;
  localparam int AB      = (ADDR_W + 7) / 8;

  // ---------------- clock / reset and DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              ctrl_valid, ctrl_ready;
  logic [1:0]        ctrl_mode;
  logic [2:0]        ctrl_nbytes;
  logic [7:0]        ibuf;
  logic              ibuf_valid, ibuf_take;
  logic [DATA_W-1:0] wr_data;
  logic              exec_pulse;
  logic [DATA_W-1:0] imm_data;
  logic              imm_valid;
  logic              mem_csel, mem_read_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, err;
  logic [1:0]        status;

  always #5 clk = ~clk;

  ctrl_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_mode(ctrl_mode), .ctrl_nbytes(ctrl_nbytes),
    .ibuf(ibuf), .ibuf_valid(ibuf_valid), .ibuf_take(ibuf_take),
    .wr_data(wr_data), .exec_pulse(exec_pulse),
    .imm_data(imm_data), .imm_valid(imm_valid),
    .mem_csel(mem_csel), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .err(err), .status(status)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Operation-level view: which operation is in flight, how many bytes are
  // still owed, how long memory has been waited on, and the visible values.
  int          m_op;      // 0 none, 1 immediate, 2 store, 3 load
  int          m_rem;     // bytes still owed from the stream
  int          m_k;       // index of next byte
  bit          m_acc;     // memory access in progress
  int          m_wait;    // cycles waited on memory
  logic [31:0] m_imm, m_addr, m_wdata, m_rd;
  bit          m_exec, m_immv, m_rdv, m_err;

  task automatic model_reset();
    m_op = 0; m_rem = 0; m_k = 0; m_acc = 0; m_wait = 0;
    m_imm = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
    m_exec = 0; m_immv = 0; m_rdv = 0; m_err = 0;
  endtask

  task automatic model_step();
    int n;
    m_exec = 0; m_immv = 0; m_rdv = 0; m_err = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_op == 0) begin
      if (ctrl_valid) begin
        if (ctrl_mode == 2'd0) m_exec = 1;
        else begin
          m_op = int'(ctrl_mode);
          m_k  = 0;
          if (m_op == 1) begin
            n = int'(ctrl_nbytes);
            if (n < 1) n = 1;
            if (n > DB) n = DB;
            m_rem = n;
            m_imm = 0;
          end else begin
            m_rem  = AB;
            m_addr = 0;
            if (m_op == 2) m_wdata = 32'(wr_data);
          end
        end
      end
    end else if (m_rem > 0) begin
      if (ibuf_valid) begin
        if (m_op == 1) m_imm = m_imm | (32'(ibuf) << (8 * m_k));
        else m_addr = (m_addr | (32'(ibuf) << (8 * m_k))) & ((32'd1 << ADDR_W) - 1);
        m_k++;
        m_rem--;
        if (m_rem == 0) begin
          if (m_op == 1) begin
            m_immv = 1;
            m_op   = 0;
          end else begin
            m_acc  = 1;
            m_wait = 0;
          end
        end
      end
    end else if (m_acc) begin
      if (mem_ready) begin
        if (m_op == 3) begin
          m_rd  = 32'(mem_rdata);
          m_rdv = 1;
        end
        m_acc = 0;
        m_op  = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_err = 1;
          m_acc = 0;
          m_op  = 0;
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic check_all();
    chk("ctrl_ready",  32'(ctrl_ready),  32'(m_op == 0));
    chk("ibuf_take",   32'(ibuf_take),   32'(ibuf_valid && (m_rem > 0)));
    chk("exec_pulse",  32'(exec_pulse),  32'(m_exec));
    chk("imm_data",    32'(imm_data),    m_imm);
    chk("imm_valid",   32'(imm_valid),   32'(m_immv));
    chk("mem_csel",    32'(mem_csel),    32'(m_acc));
    chk("mem_read_en", 32'(mem_read_en), 32'(m_acc && (m_op == 3)));
    chk("mem_addr",    32'(mem_addr),    m_addr);
    chk("mem_wdata",   32'(mem_wdata),   m_wdata);
    chk("rd_data",     32'(rd_data),     m_rd);
    chk("rd_valid",    32'(rd_valid),    32'(m_rdv));
    chk("err",         32'(err),         32'(m_err));
    chk("status",      32'(status),      32'(m_op));
  endtask

  // ---------------- driver ----------------
  // One cycle: advance model at the edge, drive new inputs on the falling
  // edge, compare just after.
  task automatic cyc(input logic r, input logic v, input logic [1:0] md, input logic [2:0] nb,
                     input logic ibv, input logic [7:0] ib, input logic rdy,
                     input logic [DATA_W-1:0] rdat);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst_n = r; ctrl_valid = v; ctrl_mode = md; ctrl_nbytes = nb;
    ibuf_valid = ibv; ibuf = ib; mem_ready = rdy; mem_rdata = rdat;
    if (!r) model_reset();
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, '0);
  endtask

  task automatic byte_cyc(input logic [7:0] b);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b1, b, 1'b0, '0);
  endtask

  task automatic cmd_cyc(input logic [1:0] md, input logic [2:0] nb);
    cyc(1'b1, 1'b1, md, nb, 1'b0, 8'h00, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  int taken;
  int csel_cnt;

  initial begin
    rst_n = 1'b0; ctrl_valid = 1'b0; ctrl_mode = 2'd0; ctrl_nbytes = 3'd0;
    ibuf = 8'h00; ibuf_valid = 1'b0; wr_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_csel", 32'(mem_csel), 32'd0);

    // 1: two-byte immediate
    cmd_cyc(2'd1, 3'd2);
    byte_cyc(8'h34);
    chk("t1_status_imm", 32'(status), 32'd1);
    byte_cyc(8'h12);
    idle_cyc();
    chk("t1_imm_data", 32'(imm_data), 32'h1234);
    chk("t1_imm_valid", 32'(imm_valid), 32'd1);
    chk("t1_status_idle", 32'(status), 32'd0);
    idle_cyc();
    chk("t1_imm_valid_drop", 32'(imm_valid), 32'd0);
    chk("t1_imm_hold", 32'(imm_data), 32'h1234);

    // 2: zero byte count treated as one
    cmd_cyc(2'd1, 3'd0);
    byte_cyc(8'hAB);
    idle_cyc();
    chk("t2_imm_data", 32'(imm_data), 32'h00AB);
    chk("t2_imm_valid", 32'(imm_valid), 32'd1);

    // 3: byte count clamped to the word size
    cmd_cyc(2'd1, 3'd5);
    taken = 0;
    byte_cyc(8'h11); taken += int'(ibuf_take);
    byte_cyc(8'h22); taken += int'(ibuf_take);
    byte_cyc(8'h33); taken += int'(ibuf_take);
    idle_cyc();
    chk("t3_taken", 32'(taken), 32'd2);
    chk("t3_imm_data", 32'(imm_data), 32'h2211);

    // 4 + 8: store with control words held during it
    wr_data = 16'h005A;
    cmd_cyc(2'd2, 3'd0);
    csel_cnt = 0;
    cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b1, 8'h80, 1'b0, '0);
    chk("t8_ctrl_ready", 32'(ctrl_ready), 32'd0);
    cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b1, 8'h00, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, '0);
      csel_cnt += int'(mem_csel);
    end
    chk("t4_addr", 32'(mem_addr), 32'h0080);
    chk("t4_wdata", 32'(mem_wdata), 32'h005A);
    chk("t4_read_en", 32'(mem_read_en), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, '0);
    csel_cnt += int'(mem_csel);
    idle_cyc();
    csel_cnt += int'(mem_csel);
    chk("t4_csel_cycles", 32'(csel_cnt), 32'd4);
    chk("t4_no_err", 32'(err), 32'd0);
    chk("t8_no_exec", 32'(exec_pulse), 32'd0);

    // 5: load with two address bytes
    cmd_cyc(2'd3, 3'd0);
    byte_cyc(8'h00);
    byte_cyc(8'h01);
    cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, 16'h00C3);
    chk("t5_addr", 32'(mem_addr), 32'h0100);
    chk("t5_read_en", 32'(mem_read_en), 32'd1);
    idle_cyc();
    chk("t5_rd_data", 32'(rd_data), 32'h00C3);
    chk("t5_rd_valid", 32'(rd_valid), 32'd1);

    // 6: load timing out
    cmd_cyc(2'd3, 3'd0);
    byte_cyc(8'h10);
    byte_cyc(8'h20);
    csel_cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, 16'hFFFF);
      csel_cnt += int'(mem_csel);
    end
    idle_cyc();
    chk("t6_csel_cycles", 32'(csel_cnt), 32'd4);
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_csel_off", 32'(mem_csel), 32'd0);
    chk("t6_status", 32'(status), 32'd0);
    chk("t6_rd_kept", 32'(rd_data), 32'h00C3);

    // 7: reset in the middle of an immediate
    cmd_cyc(2'd1, 3'd2);
    byte_cyc(8'h55);
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, '0);
    chk("t7_imm_cleared", 32'(imm_data), 32'h0000);
    chk("t7_status", 32'(status), 32'd0);
    idle_cyc();
    cmd_cyc(2'd1, 3'd2);
    byte_cyc(8'h66);
    byte_cyc(8'h77);
    idle_cyc();
    chk("t7_fresh_imm", 32'(imm_data), 32'h7766);

    // back-to-back EXEC words
    cmd_cyc(2'd0, 3'd0);
    cmd_cyc(2'd0, 3'd0);
    chk("exec_first", 32'(exec_pulse), 32'd1);
    idle_cyc();
    chk("exec_second", 32'(exec_pulse), 32'd1);
    idle_cyc();
    chk("exec_done", 32'(exec_pulse), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_data = DATA_W'($urandom);
      cyc(($urandom_range(0, 199) != 0),
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 9) < 7),
          8'($urandom),
          ($urandom_range(0, 9) < 3),
          DATA_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
